// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-Lite pipeline control logic: opcode map,
// forwarding selects, FSM states and the per-stage hazard record.
package mips_pkg;

    localparam int REGISTERWIDTH = 5;   // register index width
    localparam int Instruct      = 32;  // instruction word width

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01,
        OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_AND  = 6'h04, OP_ANDI = 6'h05,
        OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_XOR  = 6'h08, OP_XORI = 6'h09,
        OP_SLT  = 6'h0A, OP_SLTI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D,
        OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10, OP_HALT = 6'h11
    } opcode_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } pipe_state_e;

    // What the hazard logic remembers about an instruction in EX, MEM or WB.
    typedef struct packed {
        logic                     valid;
        logic                     writes;   // already cleared for rd == r0
        logic                     is_load;
        logic [REGISTERWIDTH-1:0] rd;
        logic [REGISTERWIDTH-1:0] rs1;
        logic [REGISTERWIDTH-1:0] rs2;
        logic                     uses1;
        logic                     uses2;
        logic                     is_halt;
    } hz_stage_t;

    // True when stage record p produces the register a consumer reads as src.
    function automatic logic producer_hit(hz_stage_t p, logic uses,
                                          logic [REGISTERWIDTH-1:0] src);
        return p.valid && p.writes && uses && (src != '0) && (p.rd == src);
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps a MIPS-Lite opcode to the operand/result properties the hazard logic
// needs. Unknown opcodes classify as NOP (no operands, no result).
module opcode_classifier
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output logic           uses1,
    output logic           uses2,
    output logic           writes,
    output logic           is_load,
    output logic           is_branch,
    output logic           is_halt
);

    // Decode the opcode into its operand/result flags.
    always_comb begin
        // NOTE: combinational blocks assign with '=' and give every output a
        // default first, so no path through the case can infer a latch.
        uses1     = 1'b0;
        uses2     = 1'b0;
        writes    = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                uses1  = 1'b1;
                uses2  = 1'b1;
                writes = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                uses1  = 1'b1;
                writes = 1'b1;
            end
            OP_LDW: begin
                uses1   = 1'b1;
                writes  = 1'b1;
                is_load = 1'b1;
            end
            OP_STW: begin
                uses1 = 1'b1;
                uses2 = 1'b1;
            end
            OP_BEQ: begin
                uses1     = 1'b1;
                uses2     = 1'b1;
                is_branch = 1'b1;
            end
            OP_BZ, OP_JR: begin
                uses1     = 1'b1;
                is_branch = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 5-stage MIPS-Lite core.
// Tracks EX/MEM/WB destination records and drives stall, flush, forwarding
// and the HALT drain sequence.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
// (only load-use stalls remain); otherwise fwd_a/fwd_b are 00 and ID stalls
// on any EX or MEM producer.
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int REGW = REGISTERWIDTH,
    parameter int OPW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            ex_branch_taken,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            halted
);

    logic        cls_uses1, cls_uses2, cls_writes, cls_is_load, cls_is_branch, cls_is_halt;
    hz_stage_t   id_rec, ex_q, mem_q, wb_q;
    pipe_state_e state_q;
    logic        halted_q;
    logic        stall;
    fwd_sel_e    fwd_a_sel, fwd_b_sel;

    opcode_classifier #(.OPW(OPW)) u_classifier (
        .opcode    (id_opcode),
        .uses1     (cls_uses1),
        .uses2     (cls_uses2),
        .writes    (cls_writes),
        .is_load   (cls_is_load),
        .is_branch (cls_is_branch),
        .is_halt   (cls_is_halt)
    );

    // Build the ID record; an empty ID slot yields an all-zero record that matches nothing.
    always_comb begin
        id_rec = '0;
        if (id_valid) begin
            id_rec.valid   = 1'b1;
            id_rec.writes  = cls_writes && (id_rd != '0);
            id_rec.is_load = cls_is_load;
            id_rec.rd      = id_rd;
            id_rec.rs1     = id_rs1;
            id_rec.rs2     = id_rs2;
            id_rec.uses1   = cls_uses1;
            id_rec.uses2   = cls_uses2;
            id_rec.is_halt = cls_is_halt;
        end
    end

    // Detect a RAW hazard that forces the ID instruction to wait.
    always_comb begin
        stall = 1'b0;
`ifdef HAZARD_FORWARDING_EN
        // Only a load in EX cannot be forwarded in time.
        if (ex_q.is_load) begin
            stall = producer_hit(ex_q, id_rec.uses1, id_rec.rs1) ||
                    producer_hit(ex_q, id_rec.uses2, id_rec.rs2);
        end
`else
        // WB is safe: the register file writes before it is read.
        stall = producer_hit(ex_q,  id_rec.uses1, id_rec.rs1) ||
                producer_hit(ex_q,  id_rec.uses2, id_rec.rs2) ||
                producer_hit(mem_q, id_rec.uses1, id_rec.rs1) ||
                producer_hit(mem_q, id_rec.uses2, id_rec.rs2);
`endif
    end

    // Select EX operand sources; the younger MEM result wins over WB.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
`ifdef HAZARD_FORWARDING_EN
        if (producer_hit(mem_q, ex_q.uses1, ex_q.rs1))      fwd_a_sel = FWD_MEM;
        else if (producer_hit(wb_q, ex_q.uses1, ex_q.rs1))  fwd_a_sel = FWD_WB;
        if (producer_hit(mem_q, ex_q.uses2, ex_q.rs2))      fwd_b_sel = FWD_MEM;
        else if (producer_hit(wb_q, ex_q.uses2, ex_q.rs2))  fwd_b_sel = FWD_WB;
`endif
    end

    assign fwd_a  = fwd_a_sel;
    assign fwd_b  = fwd_b_sel;
    assign halted = halted_q;

    // Derive write enables, flush and bubble from FSM state, branch and stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // Branch beats a stall: the waiting ID instruction is discarded.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (stall) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Freeze fetch and keep anything younger than HALT out of EX.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // Advance the stage records one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the stage records are discrete flops rather than a RAM, so they
        // take the reset; their valid bits must read clear out of reset.
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            // NOTE: sequential state uses '<=' so every record shifts on the
            // pre-edge value of the one ahead of it.
            ex_q  <= idex_bubble ? '0 : id_rec;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // RUN -> DRAIN -> HALTED sequencing with a registered halted flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (id_rec.is_halt && !stall && !ex_branch_taken) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wb_q.valid && wb_q.is_halt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule
